// File: rtl/right_flipper_mover.sv
// Right flipper tip animator: steps the tip between rest (35 deg down) and up (horizontal)
// once per video frame while following the flip key, and exports angle/motion flags.
module right_flipper_mover #(
    parameter int          Xc               = 455,
    parameter int          Yc               = 400,
    parameter int unsigned UP_STEP_FRAMES   = 1,
    parameter int unsigned DOWN_STEP_FRAMES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               flipKey,
    output logic signed [10:0] X1,
    output logic signed [10:0] Y1,
    output logic [2:0]         angleStep,
    output logic               flipperRising,
    output logic               flipperUp
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned STEP_W  = 3;
    localparam int unsigned COORD_W = 11;
    localparam logic [CNT_W-1:0]  UP_LAST   = CNT_W'(UP_STEP_FRAMES - 1);
    localparam logic [CNT_W-1:0]  DOWN_LAST = CNT_W'(DOWN_STEP_FRAMES - 1);
    localparam logic [STEP_W-1:0] STEP_MAX  = 3'd7;

    typedef enum logic [1:0] {
        ST_REST,
        ST_RISING,
        ST_HOLD,
        ST_FALLING
    } state_e;

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [COORD_W-1:0]  x1_q, x1_d, y1_q, y1_d;
    logic [STEP_W-1:0]   angle_q;
    logic                rising_q, up_q;

    // Tip offset ROM, 60 px lever
    function automatic logic [5:0] rom_dx(input logic [STEP_W-1:0] s);
        case (s)
            3'd0:    rom_dx = 6'd49;
            3'd1:    rom_dx = 6'd52;
            3'd2:    rom_dx = 6'd54;
            3'd3:    rom_dx = 6'd56;
            3'd4:    rom_dx = 6'd58;
            3'd5:    rom_dx = 6'd59;
            default: rom_dx = 6'd60;
        endcase
    endfunction

    function automatic logic [5:0] rom_dy(input logic [STEP_W-1:0] s);
        case (s)
            3'd0:    rom_dy = 6'd34;
            3'd1:    rom_dy = 6'd30;
            3'd2:    rom_dy = 6'd25;
            3'd3:    rom_dy = 6'd21;
            3'd4:    rom_dy = 6'd16;
            3'd5:    rom_dy = 6'd10;
            3'd6:    rom_dy = 6'd5;
            default: rom_dy = 6'd0;
        endcase
    endfunction

    // Next-state: everything advances only on the frame pulse
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        if (startOfFrame) begin
            case (state_q)
                ST_REST: begin
                    if (flipKey) begin
                        state_d = ST_RISING;
                        cnt_d   = '0;
                    end
                end
                ST_RISING: begin
                    if (!flipKey) begin
                        state_d = ST_FALLING;
                        cnt_d   = '0;
                    end else if (cnt_q == UP_LAST) begin
                        cnt_d  = '0;
                        step_d = (step_q == STEP_MAX) ? STEP_MAX : step_q + 3'd1;
                        if (step_q >= 3'd6) state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (!flipKey) begin
                        state_d = ST_FALLING;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    if (flipKey) begin
                        state_d = ST_RISING;
                        cnt_d   = '0;
                    end else if (cnt_q == DOWN_LAST) begin
                        cnt_d  = '0;
                        step_d = (step_q == 3'd0) ? 3'd0 : step_q - 3'd1;
                        if (step_q <= 3'd1) state_d = ST_REST;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            endcase
        end
        x1_d = COORD_W'(Xc - int'(rom_dx(step_q)));
        y1_d = COORD_W'(Yc + int'(rom_dy(step_q)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_REST;
            step_q   <= '0;
            cnt_q    <= '0;
            x1_q     <= COORD_W'(Xc - int'(rom_dx(3'd0)));
            y1_q     <= COORD_W'(Yc + int'(rom_dy(3'd0)));
            angle_q  <= '0;
            rising_q <= 1'b0;
            up_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            angle_q  <= step_q;
            rising_q <= (state_q == ST_RISING);
            up_q     <= (state_q == ST_HOLD);
        end
    end

    assign X1            = x1_q;
    assign Y1            = y1_q;
    assign angleStep     = angle_q;
    assign flipperRising = rising_q;
    assign flipperUp     = up_q;

endmodule
